// File: rtl/button_bank.sv
// Multi-channel push-button front end: 2-flop sync, debounce, press/release,
// long-press and auto-repeat pulses, and a wrap-around step index per channel.
module button_bank #(
  parameter int N_BTN         = 4,
  parameter int DB_CYCLES     = 500000,
  parameter int LONG_CYCLES   = 100000000,
  parameter bit REPEAT_EN     = 1'b1,
  parameter int REPEAT_CYCLES = 20000000,
  parameter int IDX_W         = 3,
  parameter int IDX_MAX       = 7
) (
  input  logic                   sys_clk,
  input  logic                   reset_n,
  input  logic [N_BTN-1:0]       btn_in,
  input  logic                   idx_clr,
  output logic [N_BTN-1:0]       btn_level,
  output logic [N_BTN-1:0]       press_pulse,
  output logic [N_BTN-1:0]       release_pulse,
  output logic [N_BTN-1:0]       long_pulse,
  output logic [N_BTN-1:0]       step_pulse,
  output logic [N_BTN*IDX_W-1:0] index
);

  localparam int DB_W   = $clog2(DB_CYCLES);
  localparam int HOLD_W = $clog2(LONG_CYCLES + REPEAT_CYCLES);

  localparam logic [DB_W-1:0]   DB_LAST      = DB_W'(DB_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LONG_M1 = HOLD_W'(LONG_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LONG    = HOLD_W'(LONG_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_REP_M1  = HOLD_W'(LONG_CYCLES + REPEAT_CYCLES - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST     = IDX_W'(IDX_MAX);

  logic [N_BTN-1:0] r_sync1;
  logic [N_BTN-1:0] r_sync2;

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= btn_in;
      r_sync2 <= r_sync1;
    end
  end

  for (genvar gi = 0; gi < N_BTN; gi++) begin : g_chan
    logic [DB_W-1:0]   r_db_cnt;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic [IDX_W-1:0]  r_idx;
    logic              r_level;
    logic              r_press;
    logic              r_release;
    logic              r_long;
    logic              r_step;
    logic              w_differ;
    logic              w_accept;
    logic              w_hold_on;
    logic              w_long_hit;
    logic              w_rep_hit;

    assign w_differ   = r_sync2[gi] ^ r_level;
    assign w_accept   = w_differ && (r_db_cnt == DB_LAST);
    // Level stays high across this edge: the only window where hold timing runs.
    assign w_hold_on  = r_level && !w_accept;
    assign w_long_hit = w_hold_on && (r_hold_cnt == HOLD_LONG_M1);
    assign w_rep_hit  = REPEAT_EN && w_hold_on &&
                        ((r_hold_cnt == HOLD_LONG_M1) || (r_hold_cnt == HOLD_REP_M1));

    always_ff @(posedge sys_clk or negedge reset_n) begin
      if (!reset_n) begin
        r_db_cnt  <= '0;
        r_level   <= 1'b0;
        r_press   <= 1'b0;
        r_release <= 1'b0;
      end else begin
        r_press   <= w_accept && !r_level;
        r_release <= w_accept && r_level;
        if (w_accept) begin
          r_level  <= !r_level;
          r_db_cnt <= '0;
        end else if (w_differ) begin
          r_db_cnt <= r_db_cnt + DB_W'(1);
        end else begin
          r_db_cnt <= '0;
        end
      end
    end

    // After each repeat the counter reloads to the long-press point, so it never wraps.
    always_ff @(posedge sys_clk or negedge reset_n) begin
      if (!reset_n) begin
        r_hold_cnt <= '0;
        r_long     <= 1'b0;
        r_step     <= 1'b0;
      end else begin
        r_long <= w_long_hit;
        r_step <= (w_accept && !r_level) || w_rep_hit;
        if (!w_hold_on) begin
          r_hold_cnt <= '0;
        end else if (REPEAT_EN && (r_hold_cnt == HOLD_REP_M1)) begin
          r_hold_cnt <= HOLD_LONG;
        end else if (REPEAT_EN || (r_hold_cnt != HOLD_LONG)) begin
          r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
        end
      end
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
      if (!reset_n) begin
        r_idx <= '0;
      end else if (idx_clr) begin
        r_idx <= '0;
      end else if (r_step) begin
        r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
      end
    end

    assign btn_level[gi]               = r_level;
    assign press_pulse[gi]             = r_press;
    assign release_pulse[gi]           = r_release;
    assign long_pulse[gi]              = r_long;
    assign step_pulse[gi]              = r_step;
    assign index[gi*IDX_W +: IDX_W]    = r_idx;
  end

endmodule
